// File: rtl/waffle_pkg.sv
// Shared types and default address map for the WAFFLE memory arbiter.
// Holds the arbiter FSM encoding, access-region encoding and address decode.
// Pure declarations; no logic, no latency, no flow control.
package waffle_pkg;

  typedef enum logic [1:0] {
    ARB      = 2'd0,
    BURST    = 2'd1,
    COOLDOWN = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_LED  = 2'd1,
    REG_SW   = 2'd2,
    REG_NONE = 2'd3
  } region_t;

  localparam int          WAFFLE_RAM_DEPTH = 900;
  localparam logic [15:0] WAFFLE_LED_ADDR  = 16'd999;
  localparam logic [15:0] WAFFLE_SW_ADDR   = 16'd998;

  // Plain 16-bit unsigned compare: nothing above the RAM ever folds back into it.
  function automatic region_t decode_region(input logic [15:0] addr,
                                            input logic [15:0] ram_end,
                                            input logic [15:0] led_addr,
                                            input logic [15:0] sw_addr);
    if (addr < ram_end)        return REG_RAM;
    else if (addr == led_addr) return REG_LED;
    else if (addr == sw_addr)  return REG_SW;
    else                       return REG_NONE;
  endfunction

endpackage

// File: rtl/waffle_ram.sv
// Single-port synchronous RAM, M10K style.
// Latency: read data appears 1 cycle after the address is presented.
// No backpressure: one access per cycle, always accepted.
module waffle_ram #(
  parameter int    DEPTH     = 900,
  parameter int    AW        = 10,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout
);

  logic [7:0] mem [0:DEPTH-1];

  // Write-first is not needed: the arbiter never reads and writes in one cycle.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/waffle_mem_arbiter.sv
// Two-master (core, DMA) arbiter for the WAFFLE RAM plus LED/SW MMIO window.
// Latency: grant is combinational; read data/rvalid one cycle after grant.
// Backpressure: a refused master simply keeps req high; starvation counter and burst cap bound waits.
module waffle_mem_arbiter
  import waffle_pkg::*;
#(
  parameter int          RAM_DEPTH = WAFFLE_RAM_DEPTH,
  parameter logic [15:0] LED_ADDR  = WAFFLE_LED_ADDR,
  parameter logic [15:0] SW_ADDR   = WAFFLE_SW_ADDR,
  parameter int          MAX_WAIT  = 4,
  parameter int          MAX_BURST = 16,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [15:0] core_addr,
  input  logic [7:0]  core_wdata,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [7:0]  core_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_lock,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [7:0]  dma_rdata,
  input  logic [7:0]  sw_in,
  output logic [7:0]  led_out,
  output logic        bus_fault
);

  localparam int          AW       = $clog2(RAM_DEPTH);
  localparam int          WW       = $clog2(MAX_WAIT + 1);
  localparam int          BW       = $clog2(MAX_BURST + 1);
  localparam logic [15:0] RAM_END  = 16'(RAM_DEPTH);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST);

  arb_state_t    state;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] beat_cnt;

  logic          pick_core, pick_dma, arb_core, arb_dma, any_gnt;
  logic          sel_we;
  logic [15:0]   sel_addr;
  logic [7:0]    sel_wdata;
  region_t       sel_region;

  logic          rd_core_q, rd_dma_q;
  region_t       rd_region_q;
  logic [7:0]    side_q, core_hold_q, dma_hold_q, ram_dout, ret_data;

  // Pick the winner: core by default, DMA when starved, locked bursts, cooldown handback.
  always_comb begin
    arb_core  = core_req && !(dma_req && (wait_cnt == WAIT_MAX));
    arb_dma   = dma_req && !arb_core;
    pick_core = 1'b0;
    pick_dma  = 1'b0;
    case (state)
      BURST: begin
        if (dma_lock) begin
          pick_dma = dma_req;
        end else begin
          pick_core = arb_core;
          pick_dma  = arb_dma;
        end
      end
      COOLDOWN: begin
        pick_core = core_req;
        pick_dma  = dma_req && !core_req;
      end
      default: begin
        pick_core = arb_core;
        pick_dma  = arb_dma;
      end
    endcase
  end

  // Reset kills grants immediately so nothing commits while it is high.
  assign core_gnt   = pick_core && !reset;
  assign dma_gnt    = pick_dma && !reset;
  assign any_gnt    = core_gnt || dma_gnt;
  assign sel_we     = dma_gnt ? dma_we    : core_we;
  assign sel_addr   = dma_gnt ? dma_addr  : core_addr;
  assign sel_wdata  = dma_gnt ? dma_wdata : core_wdata;
  assign sel_region = decode_region(sel_addr, RAM_END, LED_ADDR, SW_ADDR);

  waffle_ram #(
    .DEPTH     (RAM_DEPTH),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .we   (any_gnt && sel_we && (sel_region == REG_RAM)),
    .addr (sel_addr[AW-1:0]),
    .din  (sel_wdata),
    .dout (ram_dout)
  );

  // FSM, starvation counter and burst beat counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARB;
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      if (dma_gnt)                             wait_cnt <= '0;
      else if (dma_req && wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WW'(1);

      case (state)
        ARB: begin
          if (dma_gnt && dma_lock) begin
            state    <= BURST;
            beat_cnt <= BW'(1);
          end
        end
        BURST: begin
          if (!dma_lock) begin
            state    <= ARB;
            beat_cnt <= '0;
          end else if (dma_gnt) begin
            beat_cnt <= beat_cnt + BW'(1);
            if (beat_cnt + BW'(1) >= BEAT_MAX) state <= COOLDOWN;
          end
        end
        default: begin
          state    <= ARB;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  // MMIO side effects and the one-cycle read-return pipeline (owner + region + side data).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out     <= '0;
      bus_fault   <= 1'b0;
      rd_core_q   <= 1'b0;
      rd_dma_q    <= 1'b0;
      rd_region_q <= REG_NONE;
      side_q      <= '0;
      core_hold_q <= '0;
      dma_hold_q  <= '0;
    end else begin
      if (any_gnt && sel_we && sel_region == REG_LED) led_out <= sel_wdata;
      bus_fault   <= any_gnt && ((sel_region == REG_NONE) ||
                                 (sel_region == REG_SW && sel_we));
      rd_core_q   <= core_gnt && !core_we;
      rd_dma_q    <= dma_gnt && !dma_we;
      rd_region_q <= sel_region;
      case (sel_region)
        REG_LED: side_q <= led_out;
        REG_SW:  side_q <= sw_in;
        default: side_q <= 8'h00;
      endcase
      if (rd_core_q) core_hold_q <= ret_data;
      if (rd_dma_q)  dma_hold_q  <= ret_data;
    end
  end

  // Return path: live data in the rvalid cycle, otherwise the last delivered byte.
  always_comb begin
    ret_data    = (rd_region_q == REG_RAM) ? ram_dout : side_q;
    core_rvalid = rd_core_q;
    dma_rvalid  = rd_dma_q;
    core_rdata  = rd_core_q ? ret_data : core_hold_q;
    dma_rdata   = rd_dma_q  ? ret_data : dma_hold_q;
  end

endmodule

// File: tb/tb_waffle_mem_arbiter.sv
// Directed bench for waffle_mem_arbiter: grants, read pipeline, MMIO decode, starvation, bursts, reset.
// Inputs change 1ns after the rising edge; grants sampled 1ns later, registered outputs after the next edge.
// Every expectation is a hand-computed constant.
module tb_waffle_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we, core_gnt, core_rvalid;
  logic [15:0] core_addr;
  logic [7:0]  core_wdata, core_rdata;
  logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata;
  logic [7:0]  sw_in, led_out;
  logic        bus_fault;

  int n_checks = 0;
  int n_errs   = 0;

  waffle_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .sw_in(sw_in), .led_out(led_out), .bus_fault(bus_fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_set(input logic req, input logic we, input logic [15:0] addr, input logic [7:0] wd);
    core_req = req; core_we = we; core_addr = addr; core_wdata = wd;
  endtask

  task automatic dma_set(input logic req, input logic we, input logic lock, input logic [15:0] addr);
    dma_req = req; dma_we = we; dma_lock = lock; dma_addr = addr;
  endtask

  // One core-only access: check the grant, clock it, leave sampling of results to the caller.
  task automatic core_access(input string tag, input logic we, input logic [15:0] addr, input logic [7:0] wd);
    core_set(1'b1, we, addr, wd);
    #1;
    check_eq({tag, "_gnt"}, {31'd0, core_gnt}, 32'd1);
    tick();
    core_set(1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  logic [31:0] core_pat, dma_pat, dma_rv_pat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    core_set(1'b1, 1'b1, 16'h0010, 8'hEE);
    dma_set(1'b1, 1'b0, 1'b0, 16'h0000);
    dma_wdata = 8'h00;
    sw_in = 8'h00;
    #1;
    // Reset state: grants suppressed even with requests up.
    check_eq("rst_core_gnt", {31'd0, core_gnt}, 32'd0);
    check_eq("rst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_outs", {core_rvalid, dma_rvalid, bus_fault, core_rdata, dma_rdata, led_out}, 32'd0);
    core_set(1'b0, 1'b0, 16'h0, 8'h0);
    dma_set(1'b0, 1'b0, 1'b0, 16'h0);
    reset = 1'b0;
    tick();

    // 1: write then read back RAM 0x0010.
    core_access("t1_wr", 1'b1, 16'h0010, 8'h5A);
    check_eq("t1_wr_norv", {31'd0, core_rvalid}, 32'd0);
    core_access("t1_rd", 1'b0, 16'h0010, 8'h00);
    check_eq("t1_rvalid", {31'd0, core_rvalid}, 32'd1);
    check_eq("t1_rdata", {24'd0, core_rdata}, 32'h5A);
    tick();
    check_eq("t1_rv_drop", {31'd0, core_rvalid}, 32'd0);
    check_eq("t1_rdata_hold", {24'd0, core_rdata}, 32'h5A);

    // 2: both masters hammering; DMA wins every 5th cycle.
    core_pat = '0; dma_pat = '0; dma_rv_pat = '0;
    core_set(1'b1, 1'b0, 16'h0010, 8'h00);
    dma_set(1'b1, 1'b0, 1'b0, 16'h0020);
    for (int i = 0; i < 10; i++) begin
      #1;
      core_pat[i] = core_gnt;
      dma_pat[i]  = dma_gnt;
      tick();
      dma_rv_pat[i] = dma_rvalid;
    end
    core_set(1'b0, 1'b0, 16'h0, 8'h0);
    dma_set(1'b0, 1'b0, 1'b0, 16'h0);
    check_eq("t2_core_pat", core_pat, 32'h0000_01EF);
    check_eq("t2_dma_pat", dma_pat, 32'h0000_0210);
    check_eq("t2_dma_rv_pat", dma_rv_pat, 32'h0000_0210);
    tick();

    // 3: locked DMA burst against a busy core: 4 core, 16 DMA, cooldown core, ARB again.
    core_pat = '0; dma_pat = '0;
    core_set(1'b1, 1'b0, 16'h0010, 8'h00);
    dma_set(1'b1, 1'b0, 1'b1, 16'h0030);
    for (int i = 0; i < 25; i++) begin
      #1;
      core_pat[i] = core_gnt;
      dma_pat[i]  = dma_gnt;
      tick();
    end
    core_set(1'b0, 1'b0, 16'h0, 8'h0);
    dma_set(1'b0, 1'b0, 1'b0, 16'h0);
    check_eq("t3_core_pat", core_pat, 32'h00F0_000F);
    check_eq("t3_dma_pat", dma_pat, 32'h010F_FFF0);
    tick();

    // 4: LED and switch MMIO.
    core_access("t4_led_wr", 1'b1, 16'd999, 8'hA5);
    check_eq("t4_led", {24'd0, led_out}, 32'hA5);
    check_eq("t4_led_nofault", {31'd0, bus_fault}, 32'd0);
    sw_in = 8'h3C;
    core_access("t4_sw_rd", 1'b0, 16'd998, 8'h00);
    sw_in = 8'h00;
    check_eq("t4_sw_rv", {31'd0, core_rvalid}, 32'd1);
    check_eq("t4_sw_rdata", {24'd0, core_rdata}, 32'h3C);
    core_access("t4_led_rd", 1'b0, 16'd999, 8'h00);
    check_eq("t4_led_rdata", {24'd0, core_rdata}, 32'hA5);
    core_access("t4_sw_wr", 1'b1, 16'd998, 8'h11);
    check_eq("t4_sw_wr_fault", {31'd0, bus_fault}, 32'd1);
    check_eq("t4_sw_wr_led", {24'd0, led_out}, 32'hA5);
    tick();
    check_eq("t4_fault_pulse", {31'd0, bus_fault}, 32'd0);

    // 5: unmapped read and a write just above RAM.
    core_access("t5_unm_rd", 1'b0, 16'h1234, 8'h00);
    check_eq("t5_unm_rv", {31'd0, core_rvalid}, 32'd1);
    check_eq("t5_unm_rdata", {24'd0, core_rdata}, 32'h00);
    check_eq("t5_unm_fault", {31'd0, bus_fault}, 32'd1);
    tick();
    check_eq("t5_unm_pulse", {31'd0, bus_fault}, 32'd0);
    core_access("t5_950_wr", 1'b1, 16'd950, 8'h77);
    check_eq("t5_950_fault", {31'd0, bus_fault}, 32'd1);
    check_eq("t5_950_led", {24'd0, led_out}, 32'hA5);
    core_access("t5_ram_rd", 1'b0, 16'h0010, 8'h00);
    check_eq("t5_ram_intact", {24'd0, core_rdata}, 32'h5A);

    // 6: reset in the middle of a locked burst with a read in flight.
    dma_set(1'b1, 1'b0, 1'b1, 16'h0010);
    tick();
    tick();
    #1;
    check_eq("t6_pre_dma_gnt", {31'd0, dma_gnt}, 32'd1);
    reset = 1'b1;
    core_set(1'b1, 1'b1, 16'h0010, 8'hEE);
    #1;
    check_eq("t6_rst_gnts", {30'd0, core_gnt, dma_gnt}, 32'd0);
    check_eq("t6_rst_outs", {core_rvalid, dma_rvalid, bus_fault, core_rdata, dma_rdata, led_out}, 32'd0);
    tick();
    check_eq("t6_rst_norv", {30'd0, core_rvalid, dma_rvalid}, 32'd0);
    reset = 1'b0;
    core_set(1'b1, 1'b0, 16'h0010, 8'h00);
    #1;
    check_eq("t6_core_first", {30'd0, core_gnt, dma_gnt}, 32'd2);
    tick();
    core_set(1'b0, 1'b0, 16'h0, 8'h0);
    dma_set(1'b0, 1'b0, 1'b0, 16'h0);
    check_eq("t6_no_rst_write", {23'd0, core_rvalid, core_rdata}, 32'h15A);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errs);
    $finish;
  end

endmodule
